// File: rtl/mfcc_win_pkg.sv
// Shared types and helpers for the MFCC window buffer.
// State encoding, saturation limits and index-width helper.
package mfcc_win_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int SAT16_MAX  = 32767;
    localparam int SAT16_MIN  = -32768;

    // bits needed to index n items (0..n-1), never less than 1
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mfcc_win_ram.sv
// Simple dual-port RAM: one write port, one read port.
// Read data is registered (1-cycle latency).
module mfcc_win_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // write port and registered read port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/mfcc_window_buffer.sv
// Frames MFCC coefficients into a ring buffer and streams windows.
// Optional MFCC_SAT16_EN: saturate to signed 16-bit, 16-bit storage.
module mfcc_window_buffer
    import mfcc_win_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_COEFFS   = 16,
    parameter int NUM_FRAMES   = 32,
    parameter int STRIDE       = 4,
    parameter int SPARE_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mfcc_in,
    input  logic              mfcc_valid,
    input  logic [7:0]        num_mfcc_coeffs,
    output logic [DATA_W-1:0] feat_out,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic              feat_last,
    output logic              window_busy,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int BUF_FRAMES = NUM_FRAMES + SPARE_FRAMES;
    localparam int DEPTH = BUF_FRAMES * MAX_COEFFS;
    localparam int AW  = idx_w(DEPTH);
    localparam int SW  = idx_w(BUF_FRAMES);
    localparam int CIW = idx_w(MAX_COEFFS);
    localparam int CW  = idx_w(MAX_COEFFS + 1);
    localparam int FSW = idx_w(NUM_FRAMES + 1);
    localparam int NFW = idx_w(STRIDE + 1);
    localparam int SPW = idx_w(SPARE_FRAMES + 1);
    localparam int RCW = idx_w(NUM_FRAMES * MAX_COEFFS + 1);
`ifdef MFCC_SAT16_EN
    localparam int RW = 16;
`else
    localparam int RW = DATA_W;
`endif

    state_t state, state_nx;

    logic [CIW-1:0] coef_idx;
    logic [CW-1:0]  ncoef, ncoef_in, ncoef_cur;
    logic [SW-1:0]  wr_slot;
    logic [FSW-1:0] frames_stored;
    logic [NFW-1:0] new_frames;
    logic [SPW-1:0] spare_cnt;
    logic           drop_r, drop_now, last_word, commit, wr_en;
    logic           start, fire, room;
    logic [AW-1:0]  waddr, raddr;
    logic [RW-1:0]  wdata, rdata;

    logic [SW-1:0]  rd_slot, base_slot, iss_slot;
    logic [CIW-1:0] rd_coef, iss_coef;
    logic [CW-1:0]  ncoef_s, iss_n;
    logic [RCW-1:0] rem, iss_rem;
    logic           issue, iss_last;

    logic           pend_v, pend_l, skid_v, skid_l, out_v, out_l;
    logic [RW-1:0]  skid_q, out_q;

`ifdef MFCC_SAT16_EN
    function automatic logic [15:0] sat16(input logic [DATA_W-1:0] x);
        if ($signed(x) > SAT16_MAX) return 16'h7FFF;
        if ($signed(x) < SAT16_MIN) return 16'h8000;
        return x[15:0];
    endfunction
`endif

    // clamp programmed coefficient count to 1..MAX_COEFFS
    always_comb begin
        if (num_mfcc_coeffs == 8'd0)
            ncoef_in = CW'(1);
        else if (int'(num_mfcc_coeffs) > MAX_COEFFS)
            ncoef_in = CW'(MAX_COEFFS);
        else
            ncoef_in = CW'(num_mfcc_coeffs);
    end

    // write-side decode: frame end, drop decision, RAM write
    always_comb begin
        ncoef_cur = (coef_idx == '0) ? ncoef_in : ncoef;
        drop_now  = (coef_idx == '0)
                  ? (state == ST_STREAM && int'(spare_cnt) >= SPARE_FRAMES)
                  : drop_r;
        last_word = mfcc_valid && (int'(coef_idx) == int'(ncoef_cur) - 1);
        wr_en     = mfcc_valid && !drop_now;
        commit    = last_word && !drop_now;
        waddr     = AW'(int'(wr_slot) * MAX_COEFFS + int'(coef_idx));
`ifdef MFCC_SAT16_EN
        wdata     = sat16(mfcc_in);
`else
        wdata     = mfcc_in;
`endif
    end

    assign start = (state == ST_IDLE) &&
                   (int'(frames_stored) == NUM_FRAMES) &&
                   (int'(new_frames) >= STRIDE);

    // write pointers, frame counters and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_idx      <= '0;
            ncoef         <= CW'(1);
            drop_r        <= 1'b0;
            wr_slot       <= '0;
            frames_stored <= '0;
            new_frames    <= '0;
            spare_cnt     <= '0;
            overflow      <= 1'b0;
        end else begin
            if (mfcc_valid) begin
                if (coef_idx == '0) begin
                    ncoef  <= ncoef_in;
                    drop_r <= drop_now;
                end
                coef_idx <= last_word ? '0 : coef_idx + CIW'(1);
            end
            if (commit) begin
                wr_slot <= (int'(wr_slot) == BUF_FRAMES - 1) ? '0 : wr_slot + SW'(1);
                if (int'(frames_stored) < NUM_FRAMES)
                    frames_stored <= frames_stored + FSW'(1);
            end
            if (start)
                new_frames <= commit ? NFW'(1) : '0;
            else if (commit && int'(new_frames) < STRIDE)
                new_frames <= new_frames + NFW'(1);
            if (start)
                spare_cnt <= commit ? SPW'(1) : '0;
            else if (state == ST_STREAM && commit && int'(spare_cnt) < SPARE_FRAMES)
                spare_cnt <= spare_cnt + SPW'(1);
            if (last_word && drop_now)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

    // read issue: first read fires in the start cycle, then while space remains
    always_comb begin
        fire = out_v && feat_ready;
        room = !((out_v && !fire && (skid_v || pend_v)) || (skid_v && pend_v));
        base_slot = (int'(wr_slot) >= NUM_FRAMES)
                  ? SW'(int'(wr_slot) - NUM_FRAMES)
                  : SW'(int'(wr_slot) + BUF_FRAMES - NUM_FRAMES);
        iss_slot = start ? base_slot : rd_slot;
        iss_coef = start ? '0 : rd_coef;
        iss_n    = start ? ncoef : ncoef_s;
        iss_rem  = start ? RCW'(NUM_FRAMES * int'(ncoef)) : rem;
        issue    = start || (state == ST_STREAM && rem != '0 && room);
        iss_last = (iss_rem == RCW'(1));
        raddr    = AW'(int'(iss_slot) * MAX_COEFFS + int'(iss_coef));
    end

    // read address walk: coefficient within frame, slot wraps at BUF_FRAMES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_slot <= '0;
            rd_coef <= '0;
            ncoef_s <= CW'(1);
            rem     <= '0;
            pend_v  <= 1'b0;
            pend_l  <= 1'b0;
        end else begin
            pend_v <= issue;
            if (start) ncoef_s <= ncoef;
            if (issue) begin
                pend_l <= iss_last;
                rem    <= iss_rem - RCW'(1);
                if (int'(iss_coef) == int'(iss_n) - 1) begin
                    rd_coef <= '0;
                    rd_slot <= (int'(iss_slot) == BUF_FRAMES - 1) ? '0 : iss_slot + SW'(1);
                end else begin
                    rd_coef <= iss_coef + CIW'(1);
                    rd_slot <= iss_slot;
                end
            end
        end
    end

    // output register with skid slot so RAM data is never lost on a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v  <= 1'b0;
            out_l  <= 1'b0;
            out_q  <= '0;
            skid_v <= 1'b0;
            skid_l <= 1'b0;
            skid_q <= '0;
        end else if (!out_v || fire) begin
            if (skid_v) begin
                out_v  <= 1'b1;
                out_l  <= skid_l;
                out_q  <= skid_q;
                skid_v <= pend_v;
                skid_l <= pend_l;
                skid_q <= rdata;
            end else begin
                out_v <= pend_v;
                out_l <= pend_v && pend_l;
                if (pend_v) out_q <= rdata;
            end
        end else if (pend_v) begin
            skid_v <= 1'b1;
            skid_l <= pend_l;
            skid_q <= rdata;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // FSM next state: leave STREAM after the final word transfers
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (start) state_nx = ST_STREAM;
            ST_STREAM: if (fire && out_l) state_nx = ST_IDLE;
        endcase
    end

    // FSM and datapath outputs
    always_comb begin
        window_busy = (state == ST_STREAM);
        feat_valid  = out_v;
        feat_last   = out_l;
`ifdef MFCC_SAT16_EN
        feat_out    = {{(DATA_W-16){out_q[15]}}, out_q};
`else
        feat_out    = out_q;
`endif
    end

    mfcc_win_ram #(
        .W     (RW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (wdata),
        .re    (issue),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mfcc_window_buffer.sv
// Randomized bench for mfcc_window_buffer against a frame-list model.
// Build with MFCC_SAT16_EN to exercise 16-bit saturation.
module tb_mfcc_window_buffer;

    localparam int DW = 32, MAXC = 4, NF = 4, STR = 2, SPR = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] mfcc_in = '0;
    logic          mfcc_valid = 1'b0;
    logic [7:0]    num_mfcc_coeffs = 8'd0;
    logic [DW-1:0] feat_out;
    logic          feat_valid;
    logic          feat_ready = 1'b0;
    logic          feat_last;
    logic          window_busy;
    logic          overflow;
    logic          overflow_clr = 1'b0;

    mfcc_window_buffer #(
        .DATA_W(DW), .MAX_COEFFS(MAXC), .NUM_FRAMES(NF),
        .STRIDE(STR), .SPARE_FRAMES(SPR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mfcc_in(mfcc_in),
        .mfcc_valid(mfcc_valid), .num_mfcc_coeffs(num_mfcc_coeffs),
        .feat_out(feat_out), .feat_valid(feat_valid),
        .feat_ready(feat_ready), .feat_last(feat_last),
        .window_busy(window_busy), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int n_run = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ready pattern: 0 high, 1 toggle, 2 random, 3 low
    int rmode = 0;
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0: feat_ready = 1'b1;
            1: feat_ready = !feat_ready;
            2: feat_ready = 1'($urandom_range(0, 1));
            default: feat_ready = 1'b0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] got_d[$];
    bit          got_l[$];
    int          got_t[$];
    bit          stall_prev = 0;
    logic [31:0] prev_d;
    bit          prev_l;

    // observe transfers and stalled-output stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                check("hold_v", feat_valid, 1);
                check("hold_d", feat_out, prev_d);
                check("hold_l", feat_last, prev_l);
            end
            if (feat_valid && feat_ready) begin
                got_d.push_back(feat_out);
                got_l.push_back(feat_last);
                got_t.push_back(cyc);
            end
            stall_prev = feat_valid && !feat_ready;
            prev_d = feat_out;
            prev_l = feat_last;
        end else begin
            stall_prev = 0;
        end
    end

    // reference model: list of committed frames
    logic [31:0] fr_w[$];
    int          fr_n[$];
    int          m_stored = 0, m_new = 0, m_nc = 1, fid = 0;
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    bit          exp_c[$];
    logic [31:0] fw[4];

    function automatic logic [31:0] model_val(input logic [31:0] x);
`ifdef MFCC_SAT16_EN
        if ($signed(x) > 32767) return 32'h0000_7FFF;
        if ($signed(x) < -32768) return 32'hFFFF_8000;
        return {{16{x[15]}}, x[15:0]};
`else
        return x;
`endif
    endfunction

    function automatic int clampn(input int num);
        if (num == 0) return 1;
        if (num > MAXC) return MAXC;
        return num;
    endfunction

    task automatic model_commit(input int n);
        for (int c = 0; c < 4; c++) fr_w.push_back(model_val(fw[c]));
        fr_n.push_back(n);
        if (m_stored < NF) m_stored++;
        m_new++;
    endtask

    task automatic model_try(output bit win);
        int k0;
        win = 0;
        if (m_stored == NF && m_new >= STR) begin
            win = 1;
            m_new = 0;
            k0 = fr_n.size() - NF;
            for (int k = k0; k < k0 + NF; k++)
                for (int c = 0; c < m_nc; c++) begin
                    exp_d.push_back(fr_w[k*4 + c]);
                    exp_l.push_back(k == k0 + NF - 1 && c == m_nc - 1);
                    exp_c.push_back(fr_n[k] >= m_nc);
                end
        end
    endtask

    task automatic model_reset();
        fr_w.delete(); fr_n.delete();
        m_stored = 0; m_new = 0; m_nc = 1;
    endtask

    task automatic clear_q();
        got_d.delete(); got_l.delete(); got_t.delete();
        exp_d.delete(); exp_l.delete(); exp_c.delete();
    endtask

    task automatic fill_pat();
        for (int c = 0; c < 4; c++) fw[c] = 32'(fid * 16 + c);
    endtask

    task automatic fill_rnd();
        for (int c = 0; c < 4; c++) fw[c] = $urandom;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int num, input bit keep, input int gaps);
        int n, g;
        n = clampn(num);
        for (int c = 0; c < n; c++) begin
            g = int'($urandom_range(0, gaps));
            mfcc_valid = 1'b0;
            repeat (g) tick();
            mfcc_valid = 1'b1;
            mfcc_in = fw[c];
            num_mfcc_coeffs = 8'(num);
            tick();
        end
        mfcc_valid = 1'b0;
        m_nc = n;
        fid++;
        if (keep) model_commit(n);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (got_d.size() < exp_d.size() && t < 600) begin
            tick();
            t++;
        end
        repeat (6) tick();
        check({tag, "_len"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            if (exp_c[i]) check({tag, "_d"}, got_d[i], exp_d[i]);
            check({tag, "_l"}, got_l[i], exp_l[i]);
        end
        check({tag, "_busy"}, window_busy, 0);
    endtask

    task automatic step(input int num, input bit rnd, input string tag);
        bit w;
        if (rnd) fill_rnd(); else fill_pat();
        send_frame(num, 1, 2);
        model_try(w);
        if (w) begin
            drain(tag);
            clear_q();
        end
    endtask

    initial begin
        bit w;
        int n, t, nl;

        #12;
        check("rst_valid", feat_valid, 0);
        check("rst_last", feat_last, 0);
        check("rst_out", feat_out, 0);
        check("rst_busy", window_busy, 0);
        check("rst_ovf", overflow, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: first window, full throughput
        rmode = 0;
        for (int f = 0; f < 3; f++) step(3, 0, "t1");
        fill_pat();
        send_frame(3, 1, 2);
        model_try(w);
        check("t1_win", w, 1);
        drain("t1");
        if (got_t.size() == 12) check("t1_gap", got_t[11] - got_t[0], 11);
        else check("t1_cnt", got_t.size(), 12);
        if (got_d.size() > 3) check("t1_w3", got_d[3], 32'h10);
        clear_q();

        // 2: stride window then one frame with no window
        step(3, 0, "t2");
        step(3, 0, "t2");
        // 3: toggling ready
        rmode = 1;
        step(3, 0, "t3");
        step(3, 0, "t3");
        rmode = 0;
        fill_pat();
        send_frame(3, 1, 2);
        model_try(w);
        check("nowin_flag", w, 0);
        repeat (20) tick();
        check("nowin_n", got_d.size(), 0);
        check("nowin_busy", window_busy, 0);

        // 4: stalled window, spare frames fill, then drop
        rmode = 3;
        fill_pat();
        send_frame(3, 1, 1);
        model_try(w);
        repeat (3) tick();
        check("t4_busy", window_busy, 1);
        fill_pat(); send_frame(3, 1, 1);
        fill_pat(); send_frame(3, 1, 1);
        repeat (2) tick();
        check("t4_ovf0", overflow, 0);
        fill_pat(); send_frame(3, 0, 1);
        repeat (2) tick();
        check("t4_ovf1", overflow, 1);
        check("t4_stall", got_d.size(), 0);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("t4_clr", overflow, 0);
        model_try(w);
        check("t4_win2", w, 1);
        rmode = 0;
        drain("t4");
        clear_q();

        // 5: coefficient count clamping
        for (int f = 0; f < 4; f++) step(0, 1, "n0");
        for (int f = 0; f < 4; f++) step(9, 1, "n9");

        // random segments
        for (int s = 0; s < 6; s++) begin
            n = int'($urandom_range(0, 6));
            rmode = int'($urandom_range(0, 2));
            for (int f = 0; f < 4; f++) step(n, 1, "rnd");
        end

        // reset in the middle of a window
        rmode = 1;
        w = 0;
        for (int f = 0; f < 4 && !w; f++) begin
            fill_pat();
            send_frame(2, 1, 1);
            model_try(w);
        end
        t = 0;
        while (got_d.size() < 3 && t < 100) begin
            tick();
            t++;
        end
        check("mid_started", got_d.size() >= 3, 1);
        rst_n = 1'b0;
        #1;
        check("mid_valid", feat_valid, 0);
        check("mid_last", feat_last, 0);
        check("mid_out", feat_out, 0);
        check("mid_busy", window_busy, 0);
        nl = 0;
        foreach (got_l[i]) nl += int'(got_l[i]);
        check("mid_nolast", nl, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        model_reset();
        clear_q();
        rmode = 0;
        tick();

        // 6: saturation (or pass-through) of extreme values
        for (int f = 0; f < 4; f++) begin
            fw[0] = 32'h0001_2345;
            fw[1] = 32'hFFFE_0000;
            fw[2] = $urandom;
            fw[3] = $urandom;
            send_frame(2, 1, 1);
            model_try(w);
        end
        drain("sat");
        if (got_d.size() > 1) begin
`ifdef MFCC_SAT16_EN
            check("sat_pos", got_d[0], 32'h0000_7FFF);
            check("sat_neg", got_d[1], 32'hFFFF_8000);
`else
            check("pass_pos", got_d[0], 32'h0001_2345);
            check("pass_neg", got_d[1], 32'hFFFE_0000);
`endif
        end else begin
            check("sat_cnt", got_d.size(), 8);
        end
        clear_q();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
